// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin stream multiplexer: FSM encodings
// and the channel-index width helper.
package stream_mux_rr_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Smallest index width able to address n channels (at least 1 bit).
  function automatic int ch_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after i_ptr
// (wrapping past NUM_CH-1 to 0) wins. Produces a one-hot grant and its index.
module stream_mux_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [CH_W-1:0]   o_idx
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (int'(i_ptr) + k) % NUM_CH;
      if (!w_found && i_req[c]) begin
        w_found    = 1'b1;
        o_grant[c] = 1'b1;
        o_idx      = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with round-robin arbitration, optional
// packet lock and a single registered output stage tagged with the source channel.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter bit PKT_LOCK = 1'b1,
  parameter int CH_W     = ch_width(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  state_t              r_state;
  state_t              w_state_next;
  logic [CH_W-1:0]     r_ptr;
  logic [CH_W-1:0]     w_ptr_next;
  logic [CH_W-1:0]     r_lock_ch;
  logic [CH_W-1:0]     w_lock_ch_next;

  logic [NUM_CH-1:0]   w_arb_grant;
  logic [CH_W-1:0]     w_arb_idx;
  logic [NUM_CH-1:0]   w_grant;
  logic [CH_W-1:0]     w_sel;
  logic                w_load;
  logic                w_xfer;
  logic                w_sel_last;
  logic [WIDTH-1:0]    w_sel_data;

  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_last;
  logic [CH_W-1:0]     r_out_ch;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] idx);
    return (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
  endfunction

  stream_mux_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx)
  );

  // While locked the grant is pinned to the packet owner, even if it is idle.
  always_comb begin
    w_grant = w_arb_grant;
    w_sel   = w_arb_idx;
    if (r_state == ST_LOCK) begin
      w_grant            = '0;
      w_grant[r_lock_ch] = 1'b1;
      w_sel              = r_lock_ch;
    end
  end

  assign w_load     = !r_out_valid || out_ready;
  assign in_ready   = w_grant & {NUM_CH{w_load}};
  assign w_xfer     = |(in_valid & in_ready);
  assign w_sel_last = in_last[w_sel];
  assign w_sel_data = in_data[w_sel*WIDTH +: WIDTH];

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_lock_ch_next = r_lock_ch;
    case (r_state)
      ST_ARB: begin
        if (w_xfer) begin
          w_ptr_next = next_ch(w_sel);
          if (PKT_LOCK && !w_sel_last) begin
            w_state_next   = ST_LOCK;
            w_lock_ch_next = w_sel;
          end
        end
      end
      ST_LOCK: begin
        if (w_xfer && w_sel_last) begin
          w_state_next = ST_ARB;
          w_ptr_next   = next_ch(r_lock_ch);
        end
      end
      default: w_state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_ARB;
      r_ptr     <= '0;
      r_lock_ch <= '0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_lock_ch <= w_lock_ch_next;
    end
  end

  // Output stage: load on an accepted beat, otherwise drain when the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_ch    <= w_sel;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomised and directed bench for stream_mux_rr: a packet-lock build and a
// per-beat build share stimulus and are checked against a behavioural model.
module tb_stream_mux_rr;

  localparam int NC = 4;
  localparam int W  = 32;
  localparam int CW = 2;

  logic            clk;
  logic            rst_n;
  logic [NC-1:0]   in_valid;
  logic [NC*W-1:0] in_data;
  logic [NC-1:0]   in_last;
  logic            out_ready;

  logic [NC-1:0]   in_ready0, in_ready1;
  logic            out_valid0, out_valid1;
  logic [W-1:0]    out_data0, out_data1;
  logic            out_last0, out_last1;
  logic [CW-1:0]   out_ch0, out_ch1;

  stream_mux_rr #(.NUM_CH(NC), .WIDTH(W), .PKT_LOCK(1'b1)) u_lock (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready0), .out_valid(out_valid0),
    .out_data(out_data0), .out_last(out_last0), .out_ch(out_ch0),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.NUM_CH(NC), .WIDTH(W), .PKT_LOCK(1'b0)) u_nolock (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .out_last(out_last1), .out_ch(out_ch1),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0] d_rdy [2];
  logic          d_ov  [2];
  logic [W-1:0]  d_od  [2];
  logic          d_ol  [2];
  logic [CW-1:0] d_oc  [2];
  assign d_rdy[0] = in_ready0;  assign d_rdy[1] = in_ready1;
  assign d_ov[0]  = out_valid0; assign d_ov[1]  = out_valid1;
  assign d_od[0]  = out_data0;  assign d_od[1]  = out_data1;
  assign d_ol[0]  = out_last0;  assign d_ol[1]  = out_last1;
  assign d_oc[0]  = out_ch0;    assign d_oc[1]  = out_ch1;

  // Behavioural model: one entry per build (0 = packet lock, 1 = per-beat).
  int       m_ptr     [2];
  int       m_lock_ch [2];
  bit       m_locked  [2];
  bit       m_ev      [2];
  bit       m_el      [2];
  int       m_ech     [2];
  bit [W-1:0] m_ed    [2];
  bit       m_mode    [2] = '{1'b1, 1'b0};

  int n_pass  = 0;
  int n_total = 0;
  int log0[$];
  int log1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int winner(input int m);
    if (m_locked[m]) return m_lock_ch[m];
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (m_ptr[m] + k) % NC;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] exp_rdy(input int m);
    int w;
    w = winner(m);
    if (w >= 0 && (!m_ev[m] || out_ready)) return NC'(1 << w);
    return '0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_lock_ch[m] = 0; m_locked[m] = 0;
      m_ev[m] = 0; m_el[m] = 0; m_ech[m] = 0; m_ed[m] = '0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int w;
      bit lst;
      w = winner(m);
      if (w >= 0 && (!m_ev[m] || out_ready) && in_valid[w]) begin
        lst = in_last[w];
        m_ev[m] = 1; m_ed[m] = in_data[w*W +: W]; m_el[m] = lst; m_ech[m] = w;
        if (m_locked[m]) begin
          if (lst) begin m_locked[m] = 0; m_ptr[m] = (m_lock_ch[m] + 1) % NC; end
        end else begin
          m_ptr[m] = (w + 1) % NC;
          if (m_mode[m] && !lst) begin m_locked[m] = 1; m_lock_ch[m] = w; end
        end
      end else if (out_ready) begin
        m_ev[m] = 0;
      end
    end
  endtask

  task automatic compare();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("in_ready%0d", m), 64'(d_rdy[m]), 64'(exp_rdy(m)));
      check($sformatf("out_valid%0d", m), 64'(d_ov[m]), 64'(m_ev[m]));
      if (m_ev[m]) begin
        check($sformatf("out_data%0d", m), 64'(d_od[m]), 64'(m_ed[m]));
        check($sformatf("out_last%0d", m), 64'(d_ol[m]), 64'(m_el[m]));
        check($sformatf("out_ch%0d", m), 64'(d_oc[m]), 64'(m_ech[m]));
      end
    end
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model on the rising edge.
  task automatic cyc(input logic [NC-1:0] v, input logic [NC-1:0] l, input logic r);
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    if (rst_n) begin
      compare();
      if (out_valid0 && out_ready) log0.push_back(int'(out_ch0));
      if (out_valid1 && out_ready) log1.push_back(int'(out_ch1));
    end
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid0", 64'(out_valid0), 64'd0);
    check("rst_out_data0", 64'(out_data0), 64'd0);
    check("rst_out_last0", 64'(out_last0), 64'd0);
    check("rst_out_ch0", 64'(out_ch0), 64'd0);
    check("rst_out_valid1", 64'(out_valid1), 64'd0);
    check("rst_out_ch1", 64'(out_ch1), 64'd0);
    repeat (2) @(posedge clk);
    in_valid = '0;
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready0", 64'(in_ready0), 64'd0);
    log0.delete();
    log1.delete();
  endtask

  task automatic check_log(input string name, input int lg[$], input int exp[$]);
    for (int k = 0; k < exp.size(); k++)
      check($sformatf("%s[%0d]", name, k), 64'((k < lg.size()) ? lg[k] : 99), 64'(exp[k]));
  endtask

  initial begin
    logic [W-1:0]  hold_d;
    logic [CW-1:0] hold_c;
    logic          hold_l;
    rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    cyc(4'b1111, 4'b1010, 1'b1);  // traffic while entering reset
    do_reset();

    // Fairness: every channel requests single-beat packets.
    repeat (9) cyc(4'b1111, 4'b1111, 1'b1);
    check_log("fair0", log0, '{0, 1, 2, 3, 0, 1, 2, 3});
    check_log("fair1", log1, '{0, 1, 2, 3, 0, 1, 2, 3});

    // Backpressure: output frozen and all inputs stalled.
    hold_d = out_data0; hold_c = out_ch0; hold_l = out_last0;
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b1111, 1'b0);
      check("bp_valid", 64'(out_valid0), 64'd1);
      check("bp_data", 64'(out_data0), 64'(hold_d));
      check("bp_ch", 64'(out_ch0), 64'(hold_c));
      check("bp_last", 64'(out_last0), 64'(hold_l));
      check("bp_in_ready", 64'(in_ready0), 64'd0);
    end

    // Packet lock: ch2 sends three beats while ch0/ch1 wait.
    in_valid = '0;
    do_reset();
    cyc(4'b0100, 4'b0000, 1'b1);
    cyc(4'b0111, 4'b0000, 1'b1);
    cyc(4'b0111, 4'b0100, 1'b1);
    cyc(4'b0011, 4'b1111, 1'b1);
    cyc(4'b0011, 4'b1111, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);
    check_log("lock0", log0, '{2, 2, 2, 0, 1});
    check_log("lock1", log1, '{2, 0, 1, 0, 1});

    // Bubble inside a locked packet: ch1 goes idle for two cycles, ch0 stays stalled.
    do_reset();
    cyc(4'b0010, 4'b0000, 1'b1);
    cyc(4'b0001, 4'b0000, 1'b1);
    check("bubble_valid_a", 64'(out_valid0), 64'd0);
    check("bubble_ch0_rdy_a", 64'(in_ready0[0]), 64'd0);
    cyc(4'b0001, 4'b0000, 1'b1);
    check("bubble_valid_b", 64'(out_valid0), 64'd0);
    check("bubble_ch0_rdy_b", 64'(in_ready0[0]), 64'd0);
    cyc(4'b0011, 4'b0011, 1'b1);
    cyc(4'b0001, 4'b0001, 1'b1);
    cyc(4'b0000, 4'b0000, 1'b1);
    check_log("bubble0", log0, '{1, 1, 0});

    // Random traffic with a reset in the middle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [NC-1:0] lst;
      for (int c = 0; c < NC; c++) lst[c] = ($urandom_range(0, 2) == 0);
      if (i == 1500) do_reset();
      cyc(NC'($urandom_range(0, 15)), lst, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
